// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg: shared encodings and FTW constants for the frequency sweep engine
package freq_sweep_pkg;
  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_LIN   = 2'b01;
  localparam logic [1:0] MODE_LOG   = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;
  localparam logic [63:0] FTW_1HZ   = 64'd153722867281;
  localparam logic [63:0] FTW_1MHZ  = 64'd153722867280912930;
  localparam logic [63:0] FTW_10MHZ = 64'd1537228672809129301;
  localparam logic [63:0] FTW_20MHZ = 64'd3074457345618258603;
  localparam logic [63:0] DEF_FTW   = FTW_1HZ;
endpackage

// File: rtl/freq_next_calc.sv
// freq_next_calc: next sweep point and out-of-range flag from the current point
module freq_next_calc
  import freq_sweep_pkg::*;
#(
  parameter int FW = 64
) (
  input  logic [1:0]    mode,
  input  logic [FW-1:0] cur,
  input  logic [FW-1:0] step,
  input  logic [FW-1:0] stop,
  output logic [FW-1:0] nxt,
  output logic          ovf
);
  logic [FW:0]   lin;
  logic [FW+3:0] lg;
  // linear and x10 candidates with carry headroom; degenerate steps never advance
  always_comb begin
    lin = {1'b0, cur} + {1'b0, step};
    lg  = ({4'b0, cur} << 3) + ({4'b0, cur} << 1);
    nxt = mode == MODE_LOG ? lg[FW-1:0] : lin[FW-1:0];
    ovf = mode == MODE_LIN ? (lin[FW] || lin[FW-1:0] > stop || step == '0) :
          mode == MODE_LOG ? (lg[FW+3:FW] != '0 || lg[FW-1:0] > stop || cur == '0) :
          1'b1;
  end
endmodule

// File: rtl/freq_sweep_sequencer.sv
// freq_sweep_sequencer: steps the DDS tuning word through a fixed/linear/decade sweep
module freq_sweep_sequencer #(
  parameter int FW = 64,
  parameter int DWELL_W = 32,
  parameter logic [FW-1:0] DEF_FTW = freq_sweep_pkg::DEF_FTW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_mode,
  input  logic [FW-1:0]      cfg_start_ftw,
  input  logic [FW-1:0]      cfg_stop_ftw,
  input  logic [FW-1:0]      cfg_step_ftw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [FW-1:0]      freq_ftw,
  output logic               freq_upd,
  output logic               busy,
  output logic               done,
  output logic               wrap
);
  import freq_sweep_pkg::*;
  state_t st_q, st_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [FW-1:0] ftw_q, ftw_d, start_q, start_d, stop_q, stop_d, step_q, step_d, nxt;
  logic [1:0] mode_q, mode_d;
  logic rep_q, rep_d, upd_q, upd_d, busy_q, busy_d, done_q, done_d, wrap_q, wrap_d, ovf;
  logic [DWELL_W-1:0] dw;
  freq_next_calc #(.FW(FW)) u_calc (
    .mode(mode_q), .cur(ftw_q), .step(step_q), .stop(stop_q), .nxt(nxt), .ovf(ovf)
  );
  // sweep FSM: latch config on start, count dwell, advance/wrap/finish at dwell end
  always_comb begin
    dw = cfg_dwell == '0 ? DWELL_W'(1) : cfg_dwell;
    st_d = st_q;
    cnt_d = cnt_q;
    ftw_d = ftw_q;
    dwell_d = dwell_q;
    start_d = start_q;
    stop_d = stop_q;
    step_d = step_q;
    mode_d = mode_q;
    rep_d = rep_q;
    upd_d = 1'b0;
    done_d = 1'b0;
    wrap_d = 1'b0;
    busy_d = busy_q;
    case (st_q)
      S_IDLE: if (start && !abort) begin
        mode_d = cfg_mode;
        start_d = cfg_start_ftw;
        stop_d = cfg_stop_ftw;
        step_d = cfg_step_ftw;
        rep_d = cfg_repeat;
        dwell_d = dw;
        ftw_d = cfg_start_ftw;
        cnt_d = dw - DWELL_W'(1);
        upd_d = 1'b1;
        busy_d = 1'b1;
        st_d = S_DWELL;
      end
      S_DWELL: if (abort) begin
        busy_d = 1'b0;
        st_d = S_IDLE;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - DWELL_W'(1);
      end else if (!ovf || rep_q) begin
        ftw_d = ovf ? start_q : nxt;
        wrap_d = ovf;
        upd_d = 1'b1;
        cnt_d = dwell_q - DWELL_W'(1);
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
        st_d = S_DONE;
      end
      default: st_d = S_IDLE;
    endcase
  end
  // state and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      ftw_q <= DEF_FTW;
      dwell_q <= '0;
      start_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      mode_q <= MODE_FIXED;
      rep_q <= 1'b0;
      upd_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      ftw_q <= ftw_d;
      dwell_q <= dwell_d;
      start_q <= start_d;
      stop_q <= stop_d;
      step_q <= step_d;
      mode_q <= mode_d;
      rep_q <= rep_d;
      upd_q <= upd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end
  assign freq_ftw = ftw_q;
  assign freq_upd = upd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_freq_sweep_sequencer.sv
// tb_freq_sweep_sequencer: directed sweeps checked cycle by cycle against a queue of expected outputs
module tb_freq_sweep_sequencer;
  localparam logic [63:0] DEF = 64'd153722867281;
  localparam logic [63:0] ONES = '1;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [63:0] cfg_start_ftw = '0, cfg_stop_ftw = '0, cfg_step_ftw = '0;
  logic [31:0] cfg_dwell = '0;
  logic cfg_repeat = 1'b0, start = 1'b0, abort = 1'b0;
  logic [63:0] freq_ftw;
  logic freq_upd, busy, done, wrap;
  typedef struct packed {logic [63:0] ftw; logic upd, busy, done, wrap;} exp_t;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0, cyc = 0;

  freq_sweep_sequencer dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_start_ftw(cfg_start_ftw),
    .cfg_stop_ftw(cfg_stop_ftw), .cfg_step_ftw(cfg_step_ftw), .cfg_dwell(cfg_dwell),
    .cfg_repeat(cfg_repeat), .start(start), .abort(abort), .freq_ftw(freq_ftw),
    .freq_upd(freq_upd), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [63:0] f, input logic u, b, d, w);
    exp_t e;
    e.ftw = f; e.upd = u; e.busy = b; e.done = d; e.wrap = w;
    sb.push_back(e);
  endtask
  task automatic push_pt(input logic [63:0] f, input int n, input logic w);
    push(f, 1'b1, 1'b1, 1'b0, w);
    for (int i = 1; i < n; i++) push(f, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic push_done(input logic [63:0] f);
    push(f, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic push_idle(input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++) push(f, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic tick(input string tag);
    exp_t e, o;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o = {freq_ftw, freq_upd, busy, done, wrap};
      n_assert++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s cyc %0d: ftw/upd/busy/done/wrap got %0h/%b/%b/%b/%b want %0h/%b/%b/%b/%b",
               tag, cyc, o.ftw, o.upd, o.busy, o.done, o.wrap, e.ftw, e.upd, e.busy, e.done, e.wrap);
      end
    end
  endtask
  task automatic flush(input string tag);
    while (sb.size() > 0) tick(tag);
  endtask
  task automatic go(input logic [1:0] m, input logic [63:0] s, p, st, input logic [31:0] d,
                    input logic r);
    cfg_mode = m; cfg_start_ftw = s; cfg_stop_ftw = p; cfg_step_ftw = st;
    cfg_dwell = d; cfg_repeat = r; start = 1'b1;
  endtask

  initial begin
    push_idle(DEF, 3);
    flush("reset_held");
    #2 rst = 1'b1;
    cfg_mode = 2'b01; cfg_start_ftw = 64'd9;
    push_idle(DEF, 4);
    flush("reset_idle");

    go(2'b01, 64'd100, 64'd250, 64'd50, 32'd3, 1'b0);
    push_pt(64'd100, 3, 1'b0); push_pt(64'd150, 3, 1'b0);
    push_pt(64'd200, 3, 1'b0); push_pt(64'd250, 3, 1'b0);
    push_done(64'd250); push_idle(64'd250, 2);
    flush("lin_sweep");

    go(2'b10, 64'd1, 64'd1000, 64'd0, 32'd1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      push_pt(64'd1, 1, k != 0); push_pt(64'd10, 1, 1'b0);
      push_pt(64'd100, 1, 1'b0); push_pt(64'd1000, 1, 1'b0);
    end
    push_pt(64'd1, 1, 1'b1);
    flush("log_repeat");
    abort = 1'b1;
    push_idle(64'd1, 2);
    flush("log_abort");

    go(2'b10, 64'h2000_0000_0000_0000, ONES, 64'd0, 32'd2, 1'b0);
    push_pt(64'h2000_0000_0000_0000, 2, 1'b0);
    push_done(64'h2000_0000_0000_0000); push_idle(64'h2000_0000_0000_0000, 1);
    flush("log_carry");

    go(2'b01, 64'hFFFF_FFFF_FFFF_FF00, ONES, 64'h200, 32'd1, 1'b0);
    push_pt(64'hFFFF_FFFF_FFFF_FF00, 1, 1'b0);
    push_done(64'hFFFF_FFFF_FFFF_FF00); push_idle(64'hFFFF_FFFF_FFFF_FF00, 1);
    flush("lin_carry");

    go(2'b01, 64'd10, 64'd1000, 64'd10, 32'd4, 1'b0);
    push_pt(64'd10, 4, 1'b0);
    push(64'd20, 1'b1, 1'b1, 1'b0, 1'b0); push(64'd20, 1'b0, 1'b1, 1'b0, 1'b0);
    flush("abort_pre");
    abort = 1'b1;
    push_idle(64'd20, 3);
    flush("abort_mid_dwell");
    start = 1'b1; abort = 1'b1; cfg_start_ftw = 64'd77;
    push_idle(64'd20, 3);
    flush("start_abort_idle");

    go(2'b00, 64'd153722867280913000, ONES, 64'd1, 32'd0, 1'b0);
    push_pt(64'd153722867280913000, 1, 1'b0);
    push_done(64'd153722867280913000); push_idle(64'd153722867280913000, 1);
    flush("fixed_dwell0");

    go(2'b01, 64'd5, 64'd100, 64'd0, 32'd2, 1'b0);
    push_pt(64'd5, 2, 1'b0); push_done(64'd5); push_idle(64'd5, 2);
    repeat (3) tick("lin_step0");
    start = 1'b1;
    flush("start_in_done");

    go(2'b01, 64'd100, 64'd200, 64'd50, 32'd3, 1'b0);
    push_pt(64'd100, 3, 1'b0); push_pt(64'd150, 3, 1'b0); push_pt(64'd200, 3, 1'b0);
    push_done(64'd200); push_idle(64'd200, 1);
    repeat (4) tick("start_busy");
    cfg_start_ftw = 64'd7; cfg_step_ftw = 64'd1; cfg_dwell = 32'd1; start = 1'b1;
    flush("start_busy");

    go(2'b11, 64'd42, ONES, 64'd1, 32'd2, 1'b1);
    push_pt(64'd42, 2, 1'b0); push_pt(64'd42, 2, 1'b1);
    flush("mode3_repeat");
    abort = 1'b1;
    push_idle(64'd42, 1);
    flush("mode3_abort");

    go(2'b01, 64'd300, 64'd200, 64'd10, 32'd1, 1'b0);
    push_pt(64'd300, 1, 1'b0); push_done(64'd300); push_idle(64'd300, 1);
    flush("start_above_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
